load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side memory stage of the RV32I pipeline. It accepts one load or store request per handshake from the execute stage, holding ALU-computed address, rs2 data, funct3 and rd. It performs byte/halfword/word accesses on an internal word-wide synchronous data memory and returns sign- or zero-extended load data to the write-back path. Misaligned accesses are either split into two word beats or rejected, depending on build configuration.

## Interface
- SIZE_OF_MEMORY, 256, data memory depth in 32-bit words; power of two
- p_clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bytes used for SB/SH
- req_rd  in  5  destination register, echoed on response
- resp_valid  out  1  one-cycle response pulse
- resp_is_load  out  1  response belongs to a load
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_rd  out  5  echoed req_rd
- resp_fault  out  1  illegal funct3 or rejected misaligned access

## Operation
- Handshake: a request is accepted on a rising p_clk edge with req_valid && req_ready. The requester holds the request stable until accepted. Each accepted request yields exactly one resp_valid pulse.
- req_ready = (state == IDLE). It is low for the whole duration of an access.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other code is a fault: no memory access, resp_fault=1, resp_rdata=0.
- Word index = addr[31:2] mod SIZE_OF_MEMORY, so addresses wrap. The second beat uses (index+1) mod SIZE, so the last word wraps to word 0.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
- Byte lanes are little-endian. Stores use per-byte write enables, so no read-modify-write is needed.
- Load formatting: select bytes starting at addr[1:0] across the low word, then the high word. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states:
  - IDLE: accept. Faults go to FAULT. Loads issue a read of word A and go to LD_LO. Stores write beat 0, then go to ST_HI if split, else to DONE.
  - LD_LO: if split, capture word A, issue read of A+1, go to LD_HI; else go to FMT.
  - LD_HI: go to FMT.
  - FMT: format, register the response, go to IDLE.
  - ST_HI: write remaining bytes to A+1, go to DONE.
  - DONE/FAULT: register the response, go to IDLE.
- Memory contents are not affected by reset. They initialise to zero at time 0.

## Timing
- Request accepted at edge of cycle N. resp_valid is high during:
  - aligned load: N+2
  - split load: N+3
  - aligned store: N+1
  - split store: N+2
  - fault: N+1
- Next acceptance is possible in the cycle the response is high.
- Data memory: write on p_clk edge; read data registered, available the cycle after the address.
- Reset asserted at any time: state→IDLE, resp_valid/resp_is_load/resp_fault=0, resp_rdata=0, resp_rd=0, req_ready=1 once rst_n deasserts. An in-flight split store may leave only beat 0 written.
- All response outputs are registered. req_ready is decoded from state only.

## Configuration
- MISALIGNED_SPLIT_EN defined: misaligned accesses split into two beats as above.
- Not defined: misaligned accesses take the FAULT path (no memory access, resp_fault=1, response at N+1). States LD_HI and ST_HI are not built.

## Structure
- Shared header lsu_defines.vh holds:
  - funct3 codes: LB/LH/LW/LBU/LHU, SB/SH/SW
  - FSM state encodings
  - a macro for the misaligned check
- Sub-module data_memory: SIZE_OF_MEMORY × 32, single port, 4-bit byte write enable, registered read.
- Alignment/extension logic stays inline in load_store_unit.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → store resp at N+1 with fault 0. Load resp at N+2 with rdata 0xDEADBEEF, resp_rd echoed.
- Same word, then LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 → 0xDEAD55EF.
- With MISALIGNED_SPLIT_EN: words 0x14=0x44332211 and 0x18=0x88776655, then LW @0x16 → 0x66554433, resp at N+3, req_ready low N+1..N+2. Without the macro: fault at N+1, rdata 0.
- funct3=011 load and funct3=100 store → resp_fault=1 at N+1, and memory unchanged on read-back.
- rst_n pulsed low during LD_LO → all outputs 0, no response pulse, req_ready=1 after release, and memory retains prior values.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and decode helpers for the RV32I load/store unit.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLdLo,
        StLdHi,
        StFmt,
        StStHi,
        StDone,
        StFault
    } lsu_state_e;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;

    function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == F3Sb) || (f3 == F3Sh) || (f3 == F3Sw);
        end
        return (f3 == F3Lb) || (f3 == F3Lh) || (f3 == F3Lw) || (f3 == F3Lbu) || (f3 == F3Lhu);
    endfunction

    // f3[1:0] carries the access width for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_data_memory.sv
// Single-port word-wide data memory with byte write enables and registered read.
module load_store_unit_data_memory #(
    parameter int unsigned SIZE_OF_MEMORY = 256,
    localparam int unsigned AddrW = $clog2(SIZE_OF_MEMORY)
) (
    input  logic             p_clk,
    input  logic             re,
    input  logic [3:0]       be,
    input  logic [AddrW-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [SIZE_OF_MEMORY] = '{default: '0};

    always_ff @(posedge p_clk) begin
        if (re) begin
            rdata <= mem[addr];
        end
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-side memory stage: byte/half/word loads and stores on an internal memory.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two beats instead of faulting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned SIZE_OF_MEMORY = 256
) (
    input  logic        p_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic        resp_is_load,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault
);

    localparam int unsigned AddrW = $clog2(SIZE_OF_MEMORY);

    lsu_state_e       state;
    logic             store_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [AddrW-1:0] idx_q;
    logic [4:0]       rd_q;
    logic [31:0]      wdata_q;
    logic [31:0]      lo_q;

    logic [1:0]       req_off;
    logic [AddrW-1:0] req_idx;
    logic             req_mis;
    logic             req_fault;
    logic             unused_addr;

    assign req_off     = req_addr[1:0];
    assign req_idx     = req_addr[AddrW+1:2];
    assign unused_addr = ^req_addr[31:AddrW+2];
    assign req_mis     = is_misaligned(req_funct3, req_off);

`ifdef MISALIGNED_SPLIT_EN
    logic split_q;
    assign req_fault = !funct3_legal(req_store, req_funct3);
`else
    assign req_fault = !funct3_legal(req_store, req_funct3) || req_mis;
`endif

    assign req_ready = (state == StIdle);

    // Store lanes come from the live request while idle, from the latched copy afterwards.
    logic [1:0]  cur_off;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wdata;
    logic [63:0] st_data;
    logic [7:0]  st_be;

    assign cur_off   = req_ready ? req_off : off_q;
    assign cur_f3    = req_ready ? req_funct3 : f3_q;
    assign cur_wdata = req_ready ? req_wdata : wdata_q;
    assign st_data   = {32'h0, cur_wdata} << {cur_off, 3'b000};
    assign st_be     = {4'b0000, lane_mask(cur_f3)} << cur_off;

`ifndef MISALIGNED_SPLIT_EN
    logic unused_st;
    assign unused_st = ^{st_data[63:32], st_be[7:4]};
`endif

    logic             mem_re;
    logic [3:0]       mem_be;
    logic [AddrW-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    always_comb begin
        mem_re    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = req_idx;
        mem_wdata = st_data[31:0];
        case (state)
            StIdle: begin
                if (req_valid && !req_fault) begin
                    if (req_store) begin
                        mem_be = st_be[3:0];
                    end else begin
                        mem_re = 1'b1;
                    end
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            StLdLo: begin
                if (split_q) begin
                    mem_addr = idx_q + AddrW'(1);
                    mem_re   = 1'b1;
                end
            end
            StStHi: begin
                mem_addr  = idx_q + AddrW'(1);
                mem_be    = st_be[7:4];
                mem_wdata = st_data[63:32];
            end
`endif
            default: ;
        endcase
    end

    load_store_unit_data_memory #(
        .SIZE_OF_MEMORY(SIZE_OF_MEMORY)
    ) u_data_memory (
        .p_clk(p_clk),
        .re   (mem_re),
        .be   (mem_be),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // Low word is latched; high word stays on the memory output since no read follows it.
    logic [31:0] ld_raw;
    logic [31:0] ld_ext;

    assign ld_raw = 32'({mem_rdata, lo_q} >> {off_q, 3'b000});

    always_comb begin
        case (f3_q)
            F3Lb:    ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
            F3Lh:    ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
            F3Lbu:   ld_ext = {24'h0, ld_raw[7:0]};
            F3Lhu:   ld_ext = {16'h0, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            store_q      <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            idx_q        <= '0;
            rd_q         <= 5'd0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
`ifdef MISALIGNED_SPLIT_EN
            split_q      <= 1'b0;
`endif
            resp_valid   <= 1'b0;
            resp_is_load <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_rd      <= 5'd0;
            resp_fault   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        f3_q    <= req_funct3;
                        off_q   <= req_off;
                        idx_q   <= req_idx;
                        rd_q    <= req_rd;
                        wdata_q <= req_wdata;
`ifdef MISALIGNED_SPLIT_EN
                        split_q <= req_mis;
                        if (req_fault) begin
                            state <= StFault;
                        end else if (req_store) begin
                            state <= req_mis ? StStHi : StDone;
                        end else begin
                            state <= StLdLo;
                        end
`else
                        if (req_fault) begin
                            state <= StFault;
                        end else if (req_store) begin
                            state <= StDone;
                        end else begin
                            state <= StLdLo;
                        end
`endif
                    end
                end
                StLdLo: begin
                    lo_q <= mem_rdata;
`ifdef MISALIGNED_SPLIT_EN
                    state <= split_q ? StLdHi : StFmt;
`else
                    state <= StFmt;
`endif
                end
`ifdef MISALIGNED_SPLIT_EN
                StLdHi: state <= StFmt;
                StStHi: state <= StDone;
`endif
                StFmt: begin
                    resp_valid   <= 1'b1;
                    resp_is_load <= 1'b1;
                    resp_rdata   <= ld_ext;
                    resp_rd      <= rd_q;
                    resp_fault   <= 1'b0;
                    state        <= StIdle;
                end
                StDone: begin
                    resp_valid   <= 1'b1;
                    resp_is_load <= 1'b0;
                    resp_rdata   <= 32'h0;
                    resp_rd      <= rd_q;
                    resp_fault   <= 1'b0;
                    state        <= StIdle;
                end
                StFault: begin
                    resp_valid   <= 1'b1;
                    resp_is_load <= !store_q;
                    resp_rdata   <= 32'h0;
                    resp_rd      <= rd_q;
                    resp_fault   <= 1'b1;
                    state        <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; follows MISALIGNED_SPLIT_EN if defined.
module tb_load_store_unit;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit Split = 1'b1;
`else
    localparam bit Split = 1'b0;
`endif

    logic        p_clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_is_load;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    int n_total = 0;
    int n_bad   = 0;

    load_store_unit #(
        .SIZE_OF_MEMORY(256)
    ) dut (
        .p_clk       (p_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_is_load(resp_is_load),
        .resp_rdata  (resp_rdata),
        .resp_rd     (resp_rd),
        .resp_fault  (resp_fault)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request (called #1 after an edge with the unit idle) and check its response.
    task automatic xact(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int lat, input logic fault, input logic [31:0] exp_rdata);
        int seen;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge p_clk);
        #1;
        req_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge p_clk);
            #1;
            if (resp_valid) begin
                seen = k;
                break;
            end
            check_eq({tag, "_busy"}, {31'h0, req_ready}, 32'h0);
        end
        check_eq({tag, "_lat"}, seen, lat);
        if (seen != 0) begin
            check_eq({tag, "_fault"}, {31'h0, resp_fault}, {31'h0, fault});
            check_eq({tag, "_rdata"}, resp_rdata, exp_rdata);
            check_eq({tag, "_rd"}, {27'h0, resp_rd}, {27'h0, rd});
            check_eq({tag, "_isld"}, {31'h0, resp_is_load}, {31'h0, !st});
            check_eq({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        repeat (2) @(posedge p_clk);
        #1;
        check_eq("rst_valid", {31'h0, resp_valid}, 32'h0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge p_clk);
        #1;

        // Aligned word store/load and sub-word loads
        xact("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1,  1, 1'b0, 32'h0);
        xact("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        5'd5,  2, 1'b0, 32'hDEADBEEF);
        xact("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        5'd6,  2, 1'b0, 32'hFFFFFFDE);
        xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0,        5'd7,  2, 1'b0, 32'h000000DE);
        xact("lh12",  1'b0, 3'b001, 32'h12, 32'h0,        5'd8,  2, 1'b0, 32'hFFFFDEAD);
        xact("lhu10", 1'b0, 3'b101, 32'h10, 32'h0,        5'd9,  2, 1'b0, 32'h0000BEEF);
        xact("sb11",  1'b1, 3'b000, 32'h11, 32'h00000055, 5'd2,  1, 1'b0, 32'h0);
        xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0,        5'd10, 2, 1'b0, 32'hDEAD55EF);

        // Misaligned load spanning two words
        xact("sw14",  1'b1, 3'b010, 32'h14, 32'h44332211, 5'd3,  1, 1'b0, 32'h0);
        xact("sw18",  1'b1, 3'b010, 32'h18, 32'h88776655, 5'd4,  1, 1'b0, 32'h0);
        xact("lw16",  1'b0, 3'b010, 32'h16, 32'h0,        5'd11, Split ? 3 : 1, !Split,
             Split ? 32'h66554433 : 32'h0);
        xact("lh11",  1'b0, 3'b001, 32'h11, 32'h0,        5'd12, Split ? 3 : 1, !Split,
             Split ? 32'hFFFFAD55 : 32'h0);

        // Misaligned half store across words; a fault must leave memory untouched
        xact("sh17",  1'b1, 3'b001, 32'h17, 32'h0000AABB, 5'd13, Split ? 2 : 1, !Split, 32'h0);
        xact("lw14",  1'b0, 3'b010, 32'h14, 32'h0,        5'd14, 2, 1'b0,
             Split ? 32'hBB332211 : 32'h44332211);
        xact("lw18",  1'b0, 3'b010, 32'h18, 32'h0,        5'd15, 2, 1'b0,
             Split ? 32'h887766AA : 32'h88776655);

        // Address wrap at the top of memory
        xact("sw400", 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 5'd16, 1, 1'b0, 32'h0);
        xact("lw0",   1'b0, 3'b010, 32'h0,   32'h0,        5'd17, 2, 1'b0, 32'hCAFEF00D);
        xact("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'h12345678, 5'd18, 1, 1'b0, 32'h0);
        xact("lw3fe", 1'b0, 3'b010, 32'h3FE, 32'h0,        5'd19, Split ? 3 : 1, !Split,
             Split ? 32'hF00D1234 : 32'h0);

        // Illegal funct3 codes
        xact("ld011", 1'b0, 3'b011, 32'h10, 32'h0,        5'd20, 1, 1'b1, 32'h0);
        xact("st100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 5'd21, 1, 1'b1, 32'h0);
        xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0,        5'd22, 2, 1'b0, 32'hDEAD55EF);

        // Reset while a load sits in LD_LO
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        req_rd     = 5'd23;
        @(posedge p_clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        check_eq("mid_rst_valid", {31'h0, resp_valid}, 32'h0);
        check_eq("mid_rst_isld",  {31'h0, resp_is_load}, 32'h0);
        check_eq("mid_rst_rdata", resp_rdata, 32'h0);
        check_eq("mid_rst_rd",    {27'h0, resp_rd}, 32'h0);
        check_eq("mid_rst_fault", {31'h0, resp_fault}, 32'h0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge p_clk);
            #1;
            check_eq("post_rst_quiet", {31'h0, resp_valid}, 32'h0);
            check_eq("post_rst_ready", {31'h0, req_ready}, 32'h1);
        end
        xact("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 5'd24, 2, 1'b0, 32'hDEAD55EF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
